systolic_seq_ctrl: RTL and testbench

- Sequencer for a ROWS x COLS systolic array of reconfigurable WS/OS processing elements.
- Accepts a job (dataflow select plus reduction length) and drives the shared array-wide mode_ctrl and weight_clr lines through the clear, weight-load, compute and readout phases.
- Emits feeder strobes and indices for the skewed input/weight buffers, plus output-valid windows for the result collector.
- Sits between the layer-level scheduler (start/done handshake) and the PE array.

---
 rtl/systolic_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Phase sequencer for a ROWS x COLS WS/OS systolic array: clear, weight load, compute, readout.
// All array-facing outputs are registered decodes of the next state and counter.
module systolic_seq_ctrl #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned LEN_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode_sel,
    input  logic [LEN_WIDTH-1:0]     k_len,
    input  logic                     abort,
    output logic [1:0]               mode_ctrl,
    output logic                     weight_clr,
    output logic                     ld_en,
    output logic [$clog2(ROWS)-1:0]  ld_row,
    output logic                     feed_en,
    output logic [LEN_WIDTH-1:0]     feed_idx,
    output logic                     out_valid,
    output logic                     acc_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned RowW = $clog2(ROWS);
    localparam logic [CNT_WIDTH-1:0] Skew = CNT_WIDTH'(ROWS + COLS - 2);
    localparam longint unsigned MaxCnt = (longint'(1) << LEN_WIDTH) - longint'(1)
                                         + longint'(ROWS) + longint'(COLS) - longint'(2);

    if (MaxCnt >= (longint'(1) << CNT_WIDTH)) begin : g_cnt_width_check
        $error("systolic_seq_ctrl: CNT_WIDTH cannot hold k_len_max + ROWS + COLS - 2");
    end

    typedef enum logic [2:0] {
        StIdle, StClear, StLoad, StCompute, StRead, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   os_q, os_d;
    logic [LEN_WIDTH-1:0]   klen_q, klen_d;
    logic [CNT_WIDTH-1:0]   last_c;

    // Wraps correctly even when ROWS + COLS == 2 because k_len is never 0 here.
    assign last_c = CNT_WIDTH'(klen_q) + Skew - CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        os_d    = os_q;
        klen_d  = klen_q;
        unique case (state_q)
            StIdle: begin
                if (start && (k_len != '0)) begin
                    os_d    = mode_sel;
                    klen_d  = k_len;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = os_q ? StCompute : StLoad;
                cnt_d   = os_q ? '0 : CNT_WIDTH'(ROWS - 1);
            end
            StLoad: begin
                if (cnt_q == '0) begin
                    state_d = StCompute;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            StCompute: begin
                if (cnt_q == last_c) begin
                    state_d = os_q ? StRead : StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StRead:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    logic [1:0]           mode_ctrl_d;
    logic                 ld_en_d, feed_en_d;
    logic [RowW-1:0]      ld_row_d;
    logic [LEN_WIDTH-1:0] feed_idx_d;

    always_comb begin
        mode_ctrl_d = 2'b00;
        ld_en_d     = 1'b0;
        ld_row_d    = '0;
        feed_en_d   = 1'b0;
        feed_idx_d  = '0;
        unique case (state_d)
            StLoad: begin
                mode_ctrl_d = 2'b01;
                ld_en_d     = 1'b1;
                ld_row_d    = cnt_d[RowW-1:0];
            end
            StCompute: begin
                mode_ctrl_d = os_d ? 2'b10 : 2'b11;
                feed_en_d   = cnt_d < CNT_WIDTH'(klen_d);
                feed_idx_d  = feed_en_d ? cnt_d[LEN_WIDTH-1:0] : '0;
            end
            StRead:  mode_ctrl_d = 2'b10;
            default: mode_ctrl_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            os_q       <= 1'b0;
            klen_q     <= '0;
            mode_ctrl  <= 2'b00;
            weight_clr <= 1'b0;
            ld_en      <= 1'b0;
            ld_row     <= '0;
            feed_en    <= 1'b0;
            feed_idx   <= '0;
            out_valid  <= 1'b0;
            acc_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            os_q       <= os_d;
            klen_q     <= klen_d;
            mode_ctrl  <= mode_ctrl_d;
            weight_clr <= (state_d == StClear);
            ld_en      <= ld_en_d;
            ld_row     <= ld_row_d;
            feed_en    <= feed_en_d;
            feed_idx   <= feed_idx_d;
            out_valid  <= (state_d == StCompute) && !os_d && (cnt_d >= Skew);
            acc_valid  <= (state_d == StRead);
            busy       <= (state_d != StIdle);
            done       <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: a per-cycle expected output trace is queued
// when a job is launched and popped/compared against the DUT on every cycle.
module tb_systolic_seq_ctrl;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned LW   = 8;
    localparam int unsigned CW   = 10;

    typedef logic [18:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode_sel = 1'b0;
    logic [LW-1:0] k_len = '0;
    logic          abort = 1'b0;
    logic [1:0]    mode_ctrl;
    logic          weight_clr, ld_en, feed_en, out_valid, acc_valid, busy, done;
    logic [1:0]    ld_row;
    logic [LW-1:0] feed_idx;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t obs, exp_v;

    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel), .k_len(k_len),
        .abort(abort), .mode_ctrl(mode_ctrl), .weight_clr(weight_clr), .ld_en(ld_en),
        .ld_row(ld_row), .feed_en(feed_en), .feed_idx(feed_idx), .out_valid(out_valid),
        .acc_valid(acc_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int mc, int wc, int le, int lr, int fe, int fi,
                                int ov, int av, int bz, int dn);
        return {2'(mc), 1'(wc), 1'(le), 2'(lr), 1'(fe), 8'(fi), 1'(ov), 1'(av), 1'(bz), 1'(dn)};
    endfunction

    function automatic vec_t cur();
        return {mode_ctrl, weight_clr, ld_en, ld_row, feed_en, feed_idx,
                out_valid, acc_valid, busy, done};
    endfunction

    // Expected trace of one job, one entry per cycle starting at the CLEAR cycle.
    task automatic push_job(input int os, input int k);
        int l;
        sb.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        if (os == 0)
            for (int r = ROWS - 1; r >= 0; r--) sb.push_back(mk(1, 0, 1, r, 0, 0, 0, 0, 1, 0));
        l = k + ROWS + COLS - 2;
        for (int c = 0; c < l; c++) begin
            sb.push_back(mk(os != 0 ? 2 : 3, 0, 0, 0, c < k ? 1 : 0, c < k ? c : 0,
                            (os == 0 && c >= ROWS + COLS - 2) ? 1 : 0, 0, 1, 0));
        end
        if (os != 0) sb.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    endtask

    task automatic push_idle(input int n);
        repeat (n) sb.push_back('0);
    endtask

    task automatic sample(output vec_t v);
        @(posedge clk);
        #1;
        v = cur();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (cur() !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", cur(), vec_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(2);
        while (sb.size() != 0) begin
            sample(obs);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle: got %h want %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_job(input int os, input int k, input string name);
        int cyc = 0;
        start = 1'b1; mode_sel = 1'(os); k_len = LW'(k);
        push_job(os, k);
        push_idle(2);
        while (sb.size() != 0) begin
            sample(obs);
            cyc++;
            start = 1'b0;
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h want %h", name, cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_ignored_start();
        int cyc = 0;
        start = 1'b1; mode_sel = 1'b0; k_len = '0;
        push_idle(3);
        while (sb.size() != 0) begin
            sample(obs);
            cyc++;
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL zero_klen cycle %0d: got %h want %h", cyc, obs, exp_v);
            end
        end
        start = 1'b1; mode_sel = 1'b0; k_len = 8'd2;
        push_job(0, 2);
        push_idle(2);
        cyc = 0;
        while (sb.size() != 0) begin
            sample(obs);
            cyc++;
            // Noise on start/mode/k_len while busy must not disturb the latched job.
            start = (sb.size() > 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            mode_sel = 1'($urandom_range(0, 1));
            k_len = LW'($urandom_range(1, 255));
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL busy_start cycle %0d: got %h want %h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        start = 1'b1; mode_sel = 1'b0; k_len = 8'd3;
        sb.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        sb.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0, 1, 0));
        sb.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 1, 0));
        push_idle(3);
        while (sb.size() != 0) begin
            sample(obs);
            cyc++;
            start = 1'b0;
            abort = (cyc == 3);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL abort_load cycle %0d: got %h want %h", cyc, obs, exp_v);
            end
        end
        abort = 1'b0;
        test_job(1, 2, "os_after_abort");
    endtask

    task automatic test_reset_mid_job();
        int cyc = 0;
        start = 1'b1; mode_sel = 1'b0; k_len = 8'd3;
        push_job(0, 3);
        repeat (8) begin
            sample(obs);
            cyc++;
            start = 1'b0;
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %h want %h", cyc, obs, exp_v);
            end
        end
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cur() !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_compute: got %h want %h", cur(), vec_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(4);
        while (sb.size() != 0) begin
            sample(obs);
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_idle: got %h want %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int job1_len = 1 + ROWS + (1 + ROWS + COLS - 2) + 1;
        start = 1'b1; mode_sel = 1'b0; k_len = 8'd1;
        push_job(0, 1);
        push_idle(1);
        push_job(1, 255);
        push_idle(2);
        while (sb.size() != 0) begin
            sample(obs);
            cyc++;
            if (cyc == 1) begin
                mode_sel = 1'b1; k_len = 8'd255;
            end
            if (cyc == job1_len + 2) start = 1'b0;
            exp_v = sb.pop_front();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", cyc, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_job(0, 3, "ws_k3");
        test_job(1, 5, "os_k5");
        test_ignored_start();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
